// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes (shared with the
// ALU decoder), FSM state encoding and small operand helpers.
package muldiv_unit_pkg;

  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_iter_op(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  // Magnitude of v when treated as signed, otherwise v unchanged.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply (mode 0) or
// restoring-division step (mode 1) on the 64-bit {upper, lower} accumulator.
module muldiv_step (
  input  logic        mode,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    trial = {acc[63:32], acc[31]};
    ge    = (trial >= {1'b0, opnd});
    diff  = trial[31:0] - opnd;
    if (mode)
      acc_next = {(ge ? diff : trial[31:0]), acc[30:0], ge};
    else
      acc_next = {sum, acc[31:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: accepts an op from EX,
// runs 32 single-bit iterations, then sign-corrects and writes HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [63:0] acc_reg, acc_next, prod_fix;
  logic [31:0] opnd_reg, a_raw_reg, hi_reg, lo_reg, quot_fix, rem_fix;
  logic        is_div_reg, neg_q_reg, neg_r_reg, dz_reg, busy_reg, done_reg;
  logic        accept, ld_signed, ld_div;
  logic [31:0] a_mag, b_mag;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_iter_op(op)) state_next = RUN;
      RUN:     if (cnt_reg == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall   = busy_reg & start & is_muldiv_op(op);
    rd_data = 32'd0;
    if (op == OP_MFHI)      rd_data = hi_reg;
    else if (op == OP_MFLO) rd_data = lo_reg;
  end

  assign accept    = start & ~stall & (state_reg == IDLE);
  assign ld_signed = (op == OP_MULT) || (op == OP_DIV);
  assign ld_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_mag     = mag(src_a, ld_signed);
  assign b_mag     = mag(src_b, ld_signed);

  muldiv_step u_step (
    .mode     (is_div_reg),
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .acc_next (acc_next)
  );

  // Sign correction; the most-negative / -1 case wraps back to 0x8000_0000 naturally.
  assign prod_fix = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
  assign quot_fix = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
  assign rem_fix  = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 5'd0;
      acc_reg    <= 64'd0;
      opnd_reg   <= 32'd0;
      a_raw_reg  <= 32'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: if (accept) begin
          if (op == OP_MTHI) hi_reg <= src_a;
          if (op == OP_MTLO) lo_reg <= src_a;
          if (is_iter_op(op)) begin
            cnt_reg    <= 5'd0;
            is_div_reg <= ld_div;
            acc_reg    <= {32'd0, (ld_div ? a_mag : b_mag)};
            opnd_reg   <= ld_div ? b_mag : a_mag;
            a_raw_reg  <= src_a;
            neg_q_reg  <= ld_signed & (src_a[31] ^ src_b[31]);
            neg_r_reg  <= ld_signed & src_a[31];
            dz_reg     <= (src_b == 32'd0);
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 5'd1;
        end
        FIX: begin
          if (!is_div_reg) begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end else if (dz_reg) begin
            hi_reg <= a_raw_reg;
            lo_reg <= 32'hFFFF_FFFF;
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results computed with
// plain arithmetic; a negedge monitor pops and compares on done and on HI/LO reads.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] hi, lo, rd_data;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  exp_t        mon_e;
  logic        done_prev = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] model_hi = 0, model_lo = 0, vis_hi = 0, vis_lo = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference results straight from the architectural rules.
  function automatic logic [63:0] ref_result(input logic [5:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, r;
    case (o)
      OP_MULT:  begin sa = $signed(a); sb = $signed(b); return 64'(sa * sb); end
      OP_MULTU: begin ua = 64'(a); ub = 64'(b); return ua * ub; end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a); ib = $signed(b);
        q = ia / ib; r = ia % ib;
        return {32'(r), 32'(q)};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("done_single_pulse", {31'd0, done_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done: done=1 but no result expected (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_hi", hi, mon_e.hi);
          check("result_lo", lo, mon_e.lo);
          check("result_latency", cyc, mon_e.due);
          $display("done: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        n_cmp++; n_bad++;
        $display("FAIL done_timeout: done=0 at cycle %0d, required 1", cyc);
        void'(exp_q.pop_front());
      end
      if (start && !stall && (op == OP_MFHI || op == OP_MFLO)) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: read accepted with no expectation, rd_data=%h", rd_data);
        end else begin
          check((op == OP_MFHI) ? "mfhi_rd_data" : "mflo_rd_data", rd_data, rd_q.pop_front());
        end
      end
    end
    done_prev <= done;
  end

  // Present one op, hold it while stalled, record expectations on acceptance.
  // Called and returns at posedge+1.
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    logic [63:0] r;
    logic        ok;
    op = o; src_a = a; src_b = b; start = 1'b1;
    stalls = 0; ok = 1'b1;
    forever begin
      #1;
      if (!stall) break;
      check("hold_hi_while_busy", hi, vis_hi);
      check("hold_lo_while_busy", lo, vis_lo);
      stalls++;
      if (stalls > 100) begin
        n_cmp++; n_bad++; ok = 1'b0;
        $display("FAIL stall_timeout: stall=1 for %0d cycles, op=%0d", stalls, o);
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      $display("issue op=%0d a=%h b=%h stalls=%0d", o, a, b, stalls);
      if (is_iter_op(o)) begin
        vis_hi = model_hi; vis_lo = model_lo;
        r = ref_result(o, a, b);
        model_hi = r[63:32]; model_lo = r[31:0];
        exp_q.push_back('{hi: r[63:32], lo: r[31:0], due: cyc + 34});
      end else if (o == OP_MTHI) begin
        model_hi = a; vis_hi = a;
      end else if (o == OP_MTLO) begin
        model_lo = a; vis_lo = a;
      end else if (o == OP_MFHI) begin
        rd_q.push_back(model_hi);
      end else if (o == OP_MFLO) begin
        rd_q.push_back(model_lo);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] op_tab [10];
  initial begin
    int          s, nb;
    logic [31:0] ra, rb;
    op_tab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
               6'd5, OP_DIV};

    // Reset state
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Case 1: signed multiply, busy for 33 cycles
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, s);
    nb = 0;
    while (busy && nb < 60) begin nb++; @(posedge clk); #1; end
    check("case1_busy_cycles", nb, 33);
    issue(OP_MFHI, 0, 0, s);
    issue(OP_MFLO, 0, 0, s);

    // Case 2: unsigned max x max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    // Case 3: signed division and the overflow corner
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, s);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
    // Case 4: divide by zero
    issue(OP_DIVU, 32'd5, 32'd0, s);
    issue(OP_DIV, 32'hFFFF_FF00, 32'd0, s);

    // Case 5: mflo / mthi held while a divide runs
    issue(OP_DIVU, 32'd100, 32'd7, s);
    idle(2);
    issue(OP_MFLO, 0, 0, s);
    check("case5_mflo_stall_cycles", s, 31);
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD, s);
    idle(2);
    issue(OP_MTHI, 32'hAAAA_5555, 0, s);
    check("case5_mthi_stall_cycles", s, 31);
    issue(OP_MFHI, 0, 0, s);
    issue(OP_MFLO, 0, 0, s);

    // Randomized mix
    for (int i = 0; i < 30; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      issue(op_tab[$urandom_range(0, 9)], ra, rb, s);
      idle($urandom_range(0, 2));
    end
    nb = 0;
    while (exp_q.size() > 0 && nb < 100) begin nb++; idle(1); end

    // Case 6: asynchronous reset mid-multiply
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, s);
    idle(9);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); rd_q.delete();
    model_hi = 0; model_lo = 0; vis_hi = 0; vis_lo = 0;
    #1;
    check("case6_reset_busy", {31'd0, busy}, 32'd0);
    check("case6_reset_done", {31'd0, done}, 32'd0);
    check("case6_reset_hi", hi, 32'd0);
    check("case6_reset_lo", lo, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(40);
    check("case6_idle_after_reset", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h0000_1234, 0, s);
    check("case6_mtlo_lo", lo, 32'h0000_1234);
    issue(OP_MFLO, 0, 0, s);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
